aes_inv_sub_bytes: RTL



---
 rtl/aes_inv_sub_bytes.sv | 131 +++++++++++++
 1 files changed

// File: rtl/aes_inv_sub_bytes.sv
// AES InvSubBytes engine: substitutes LANES bytes of a 128-bit state per cycle.
// Define AES_INV_SBOX_CALC_EN to compute the inverse S-box arithmetically instead of by table.
module aes_inv_sub_bytes #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int unsigned   N        = 16 / LANES;
    localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

`ifdef AES_INV_SBOX_CALC_EN
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        logic [7:0] sq;
        logic [7:0] acc;
        b   = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        sq  = b;
        acc = 8'h01;
        // b^254 = b^2 * b^4 * ... * b^128, which is the field inverse and maps 0 to 0
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction
`else
    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return INV_SBOX[{~a, 3'b000} +: 8];
    endfunction
`endif

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    logic [3:0]     byte_idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        byte_idx  = '0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    byte_idx = 4'(32'(cnt_q) * LANES + l);
                    work_d[{byte_idx, 3'b000} +: 8] = inv_sbox(work_q[{byte_idx, 3'b000} +: 8]);
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = !rst;
                in_ready  = out_ready && !rst;
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = in_state;
                        cnt_d   = '0;
                        state_d = SUB;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign out_state = work_q;
    assign busy      = (state_q != IDLE);

endmodule
